scoreboard_hazard_unit: RTL and testbench
=========================================

Name: scoreboard_hazard_unit

Overview:
- Parametrised successor to the fixed 3-stage hazard detector.
- Keeps its own shift-register record of in-flight register writes. Callers no longer feed per-stage write addresses and flags.
- Each cycle it produces stall and per-operand forward selects for the instruction in ID, for a configurable pipeline depth and per-class result latency.
- Sits beside the decode controller and drives the ID/EX operand muxes and the PC/IF_ID hold.

Parameters:
- REG_AW, 3, register address width (2^REG_AW architectural registers).
- DEPTH, 4, number of tracked post-ID stages. Stage 1 = ID/EX, stage DEPTH = last stage before register-file write.
- ALU_READY, 2, first stage (1..DEPTH) at which a non-load result can be forwarded.
- LOAD_READY, 3, first stage (ALU_READY..DEPTH) at which a load result can be forwarded.
- FSEL_W, 3, forward-select width; must satisfy 2^FSEL_W > DEPTH.
- STALL_CNT_W, 16, stall-cycle counter width.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, reset, asynchronous and active-low.
- id_valid, input, 1, ID holds a real instruction.
- id_src_a, input, REG_AW, source A register.
- id_src_a_used, input, 1, the instruction reads source A.
- id_src_b, input, REG_AW, source B register.
- id_src_b_used, input, 1, the instruction reads source B (0 for immediate forms).
- id_dst, input, REG_AW, destination register.
- id_reg_write, input, 1, the instruction writes id_dst.
- id_is_load, input, 1, the instruction is a memory load.
- flush, input, 1, branch taken; squash the ID instruction.
- stall, output, 1, hold PC and IF_ID this cycle.
- fwd_a, output, FSEL_W, source A select: 0 = register file, s = stage s.
- fwd_b, output, FSEL_W, source B select, same encoding as fwd_a.
- rf_commit, output, 1, the stage-DEPTH entry writes the register file this cycle.
- rf_commit_addr, output, REG_AW, register address of that write.
- stall_count, output, STALL_CNT_W, saturating count of stall cycles.

Behaviour:
- State: entries e[1..DEPTH], each holding {v, addr, is_load}.
- Every clock edge: e[s+1] <= e[s] for s = 1..DEPTH-1. The stage-DEPTH entry retires.
- e[1] <= {id_valid & id_reg_write & ~stall & ~flush, id_dst, id_is_load}.
- A stall or flush therefore inserts a bubble (v = 0) into stage 1.
- Lookup per used source X:
  - Match = lowest s with e[s].v and e[s].addr == X; the youngest producer wins.
  - Ready(s) = s >= (e[s].is_load ? LOAD_READY : ALU_READY).
  - No match: fwd = 0.
  - Match and ready: fwd = s.
  - Match and not ready: that source raises stall.
- Unused source: fwd = 0 and no stall contribution.
- Older matches behind the youngest match are ignored.
- stall = id_valid & ~flush & (stall_a | stall_b).
- When stall = 1, fwd_a and fwd_b are both forced to 0.
- Outputs are combinational from the current entries and the ID inputs; there is no output latency.
- The register file is written at the edge that retires stage DEPTH. From the next cycle the value is read from the register file with fwd = 0.
- rf_commit = e[DEPTH].v and rf_commit_addr = e[DEPTH].addr.
- stall_count increments by 1 on every cycle where stall = 1. It saturates at all-ones and never wraps.
- Simultaneous flush and stall condition: flush wins, stall = 0, no count increment, bubble pushed.
- Both sources name the same pending register: identical fwd values, single stall.
- A source matching id_dst of the current ID instruction is not a self-hazard; only e[1..DEPTH] is consulted.
- Reset, asynchronous including mid-operation: all e[s].v = 0 and stall_count = 0. This gives stall = 0, fwd_a = fwd_b = 0 and rf_commit = 0 immediately, independent of clk.
- Parameter check: LOAD_READY < ALU_READY, LOAD_READY > DEPTH, or 2^FSEL_W <= DEPTH triggers a fatal elaboration error.

Test Plan (defaults unless stated):
- ADD r1 issued, next cycle ADD r2 <- r1, r1. Required: stall = 1 for 1 cycle (r1 at stage 1), then fwd_a = fwd_b = 2 with stall = 0. Next, r2 producer is at stage 1.
- LD r3 followed by an r3 consumer. Required: stall = 1 for 2 cycles, then fwd_a = 3. Then stall_count = 2.
- ADD r4, two unrelated instructions, then an r4 reader. Required: fwd_a = 3.
  - After DEPTH cycles, rf_commit = 1 with addr 4.
  - A reader one cycle later gets fwd_a = 0.
- Two writes to r5 back-to-back, then a reader once both are ready. Required: fwd selects the younger stage (lower s), not the older.
- flush = 1 together with a pending stall condition. Required: stall = 0, stage 1 v = 0 next cycle, stall_count unchanged.
- Run with stall_count preloaded near max (STALL_CNT_W = 2, 5 stall cycles). Required: the count reads 3 and holds.
- Assert rst_n low mid-stream with 3 valid entries. Required: outputs clear asynchronously; after release, a reader of the previously pending register gets fwd = 0 and stall = 0.

Source files
------------

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit
//   Tracks in-flight register writes in a DEPTH-entry shift record and, for
//   the instruction sitting in ID, decides whether it must stall and where
//   each used source operand should be taken from (register file or a
//   post-ID stage). Also reports the retiring write and counts stall cycles.
//   All decision outputs are combinational from the record and ID inputs.
module scoreboard_hazard_unit #(
  parameter int REG_AW      = 3,
  parameter int DEPTH       = 4,
  parameter int ALU_READY   = 2,
  parameter int LOAD_READY  = 3,
  parameter int FSEL_W      = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      id_src_a,
  input  logic                   id_src_a_used,
  input  logic [REG_AW-1:0]      id_src_b,
  input  logic                   id_src_b_used,
  input  logic [REG_AW-1:0]      id_dst,
  input  logic                   id_reg_write,
  input  logic                   id_is_load,
  input  logic                   flush,
  output logic                   stall,
  output logic [FSEL_W-1:0]      fwd_a,
  output logic [FSEL_W-1:0]      fwd_b,
  output logic                   rf_commit,
  output logic [REG_AW-1:0]      rf_commit_addr,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Reject configurations where a load could be ready before an ALU result,
  // could never become ready, or where a stage number does not fit the select.
  if ((LOAD_READY < ALU_READY) || (LOAD_READY > DEPTH) ||
      ((64'd1 << FSEL_W) <= 64'(DEPTH))) begin : g_param_err
    $fatal(1, "scoreboard_hazard_unit: illegal parameter combination");
  end

  // Result of looking one source operand up in the in-flight record.
  typedef struct packed {
    logic              blocked;  // youngest producer exists but is not ready
    logic [FSEL_W-1:0] sel;      // forward select (0 = register file)
  } lookup_t;

  // In-flight record, stage 1 (ID/EX) .. stage DEPTH (last before RF write).
  logic [DEPTH:1]             v_q,    v_d;
  logic [DEPTH:1][REG_AW-1:0] addr_q, addr_d;
  logic [DEPTH:1]             ld_q,   ld_d;

  logic [STALL_CNT_W-1:0]     cnt_q,  cnt_d;

  lookup_t                    look_a_s;
  lookup_t                    look_b_s;
  logic                       stall_s;

  // Search the record from oldest to youngest so the lowest matching stage
  // (the youngest producer) is the one left standing; older matches behind
  // it are thereby ignored. A match only forwards once its stage has reached
  // the class-specific ready stage, otherwise the operand is blocked.
  function automatic lookup_t lookup(
    input logic [REG_AW-1:0]             src,
    input logic                          used,
    input logic [DEPTH:1]                v,
    input logic [DEPTH:1][REG_AW-1:0]    addr,
    input logic [DEPTH:1]                ld
  );
    lookup_t res;
    int      thr;
    res = '0;
    for (int s = DEPTH; s >= 1; s--) begin
      thr = ld[s] ? LOAD_READY : ALU_READY;
      if (used && v[s] && (addr[s] == src)) begin
        res.sel     = FSEL_W'(s);
        res.blocked = (s < thr);
      end else begin
        res = res;
      end
    end
    if (res.blocked) begin
      res.sel = '0;
    end else begin
      res.sel = res.sel;
    end
    return res;
  endfunction

  // Per-operand lookup and the combined stall/forward decision for ID.
  always_comb begin
    look_a_s = lookup(id_src_a, id_src_a_used, v_q, addr_q, ld_q);
    look_b_s = lookup(id_src_b, id_src_b_used, v_q, addr_q, ld_q);
    stall_s  = id_valid & ~flush & (look_a_s.blocked | look_b_s.blocked);
    if (stall_s) begin
      fwd_a = '0;
      fwd_b = '0;
    end else begin
      fwd_a = look_a_s.sel;
      fwd_b = look_b_s.sel;
    end
  end

  assign stall          = stall_s;
  assign rf_commit      = v_q[DEPTH];
  assign rf_commit_addr = addr_q[DEPTH];
  assign stall_count    = cnt_q;

  // Next record: everything advances one stage; stage 1 takes the ID write,
  // or a bubble when ID is empty, does not write, stalls or is flushed.
  always_comb begin
    v_d       = v_q;
    addr_d    = addr_q;
    ld_d      = ld_q;
    v_d[1]    = id_valid & id_reg_write & ~stall_s & ~flush;
    addr_d[1] = id_dst;
    ld_d[1]   = id_is_load;
    for (int s = 2; s <= DEPTH; s++) begin
      v_d[s]    = v_q[s-1];
      addr_d[s] = addr_q[s-1];
      ld_d[s]   = ld_q[s-1];
    end
  end

  // Next stall count: one more per stalled cycle, holding at all-ones.
  always_comb begin
    if (stall_s && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Record registers; reset empties every stage at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      addr_q <= '0;
      ld_q   <= '0;
    end else begin
      v_q    <= v_d;
      addr_q <= addr_d;
      ld_q   <= ld_d;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed-vector bench for scoreboard_hazard_unit. The stimulus process
// drives one ID instruction per cycle and queues the hand-computed response;
// a monitor on the falling edge pops and compares. A second instance with a
// 2-bit stall counter shares the stimulus to exercise saturation.
module tb_scoreboard_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_src_a;
  logic       id_src_a_used;
  logic [2:0] id_src_b;
  logic       id_src_b_used;
  logic [2:0] id_dst;
  logic       id_reg_write;
  logic       id_is_load;
  logic       flush;

  logic        stall;
  logic [2:0]  fwd_a;
  logic [2:0]  fwd_b;
  logic        rf_commit;
  logic [2:0]  rf_commit_addr;
  logic [15:0] stall_count;

  logic        s_stall;
  logic [2:0]  s_fwd_a;
  logic [2:0]  s_fwd_b;
  logic        s_rf_commit;
  logic [2:0]  s_rf_commit_addr;
  logic [1:0]  s_stall_count;

  typedef struct {
    int         tag;
    logic       stall;
    logic [2:0] fa;
    logic [2:0] fb;
    logic       commit;
    logic [2:0] caddr;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  scoreboard_hazard_unit u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_a_used(id_src_a_used),
    .id_src_b(id_src_b), .id_src_b_used(id_src_b_used),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .rf_commit(rf_commit), .rf_commit_addr(rf_commit_addr),
    .stall_count(stall_count)
  );

  scoreboard_hazard_unit #(.STALL_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_a_used(id_src_a_used),
    .id_src_b(id_src_b), .id_src_b_used(id_src_b_used),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .flush(flush), .stall(s_stall), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .rf_commit(s_rf_commit), .rf_commit_addr(s_rf_commit_addr),
    .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", nm, tag, act, exp);
    end
  endtask

  // One cycle of stimulus plus its expected response.
  task automatic step(
    input logic v, input logic [2:0] sa, input logic ua,
    input logic [2:0] sb, input logic ub,
    input logic [2:0] dst, input logic rw, input logic ld, input logic fl,
    input logic e_st, input logic [2:0] e_fa, input logic [2:0] e_fb,
    input logic e_com, input logic [2:0] e_caddr, input int e_cnt
  );
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v;  id_src_a = sa; id_src_a_used = ua;
    id_src_b = sb; id_src_b_used = ub;
    id_dst = dst;  id_reg_write = rw; id_is_load = ld; flush = fl;
    e.tag = cyc; e.stall = e_st; e.fa = e_fa; e.fb = e_fb;
    e.commit = e_com; e.caddr = e_caddr; e.cnt = e_cnt;
    exp_q.push_back(e);
    cyc++;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("stall", mon_e.tag, int'(stall), int'(mon_e.stall));
        chk("fwd_a", mon_e.tag, int'(fwd_a), int'(mon_e.fa));
        chk("fwd_b", mon_e.tag, int'(fwd_b), int'(mon_e.fb));
        chk("rf_commit", mon_e.tag, int'(rf_commit), int'(mon_e.commit));
        if (mon_e.commit) begin
          chk("rf_commit_addr", mon_e.tag, int'(rf_commit_addr), int'(mon_e.caddr));
        end
        chk("stall_count", mon_e.tag, int'(stall_count), mon_e.cnt);
        chk("stall_count_sat", mon_e.tag, int'(s_stall_count),
            (mon_e.cnt > 3) ? 3 : mon_e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  exp_t rst_e;

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b1; id_src_a = 3'd1; id_src_a_used = 1'b1;
    id_src_b = 3'd1; id_src_b_used = 1'b1;
    id_dst = 3'd0; id_reg_write = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    rst_e.tag = -1; rst_e.stall = 1'b0; rst_e.fa = 3'd0; rst_e.fb = 3'd0;
    rst_e.commit = 1'b0; rst_e.caddr = 3'd0; rst_e.cnt = 0;
    exp_q.push_back(rst_e);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    //    v sa ua sb ub dst rw ld fl  st fa fb com ad cnt
    // ADD r1, then ADD r2 <- r1,r1: one stall then forward from stage 2
    step(1, 0,0, 0,0, 1,1,0, 0,   0,0,0, 0,0, 0);
    step(1, 1,1, 1,1, 2,1,0, 0,   1,0,0, 0,0, 0);
    step(1, 1,1, 1,1, 2,1,0, 0,   0,2,2, 0,0, 1);
    // LD r3 then r3 consumer: two stalls then forward from stage 3
    step(1, 0,0, 0,0, 3,1,1, 0,   0,0,0, 0,0, 1);
    step(1, 3,1, 0,0, 6,1,0, 0,   1,0,0, 1,1, 1);
    step(1, 3,1, 0,0, 6,1,0, 0,   1,0,0, 0,0, 2);
    step(1, 3,1, 0,0, 6,1,0, 0,   0,3,0, 1,2, 3);
    // ADD r4, two unrelated, reader at stage 3, at DEPTH, then from RF
    step(1, 0,0, 0,0, 4,1,0, 0,   0,0,0, 1,3, 3);
    step(1, 0,0, 0,0, 7,1,0, 0,   0,0,0, 0,0, 3);
    step(1, 0,0, 0,0, 0,0,0, 0,   0,0,0, 0,0, 3);
    step(1, 4,1, 7,1, 0,0,0, 0,   0,3,2, 1,6, 3);
    step(1, 4,1, 0,0, 0,0,0, 0,   0,4,0, 1,4, 3);
    step(1, 4,1, 0,0, 0,0,0, 0,   0,0,0, 1,7, 3);
    // two writes to r5; reader picks the younger stage
    step(1, 0,0, 0,0, 5,1,0, 0,   0,0,0, 0,0, 3);
    step(1, 0,0, 0,0, 5,1,0, 0,   0,0,0, 0,0, 3);
    step(1, 0,0, 0,0, 0,0,0, 0,   0,0,0, 0,0, 3);
    step(1, 5,1, 5,1, 0,0,0, 0,   0,2,2, 0,0, 3);
    // young unready load shadows an older ready r5 producer
    step(1, 0,0, 0,0, 5,1,1, 0,   0,0,0, 1,5, 3);
    step(1, 5,1, 0,0, 0,0,0, 0,   1,0,0, 1,5, 3);
    // flush with a pending stall: no stall, no count, bubble in stage 1
    step(1, 5,1, 0,0, 6,1,0, 1,   0,0,0, 0,0, 4);
    step(1, 6,1, 5,1, 0,0,0, 0,   0,0,3, 0,0, 4);
    // source equal to own destination is not a hazard
    step(1, 2,1, 0,0, 2,1,0, 0,   0,0,0, 1,5, 4);
    // both sources on the same pending register: single stall
    step(1, 2,1, 2,1, 0,0,0, 0,   1,0,0, 0,0, 4);
    step(1, 2,1, 2,1, 0,0,0, 0,   0,2,2, 0,0, 5);
    // build three valid entries, then reset mid-stream
    step(1, 0,0, 0,0, 1,1,0, 0,   0,0,0, 0,0, 5);
    step(1, 0,0, 0,0, 3,1,1, 0,   0,0,0, 1,2, 5);
    step(1, 0,0, 0,0, 4,1,0, 0,   0,0,0, 0,0, 5);
    step(1, 3,1, 0,0, 0,0,0, 0,   1,0,0, 0,0, 5);
    #6;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", cyc, int'(stall), 0);
    chk("async_rst_fwd_a", cyc, int'(fwd_a), 0);
    chk("async_rst_fwd_b", cyc, int'(fwd_b), 0);
    chk("async_rst_commit", cyc, int'(rf_commit), 0);
    chk("async_rst_count", cyc, int'(stall_count), 0);
    chk("async_rst_count_sat", cyc, int'(s_stall_count), 0);
    step(1, 3,1, 0,0, 0,0,0, 0,   0,0,0, 0,0, 0);
    #5;
    rst_n = 1'b1;
    step(1, 3,1, 4,1, 0,0,0, 0,   0,0,0, 0,0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("queue_drained", cyc, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
